// File: rtl/mhsa_pkg.sv
// Shared types and stage indices for the multi-head self-attention layer scheduler.
package mhsa_pkg;

  localparam int NUM_STAGES = 7;

  localparam int STG_LIN_Q   = 0;
  localparam int STG_LIN_K   = 1;
  localparam int STG_LIN_V   = 2;
  localparam int STG_QK      = 3;
  localparam int STG_SOFTMAX = 4;
  localparam int STG_SV      = 5;
  localparam int STG_LIN_O   = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } mhsa_state_e;

endpackage

// File: rtl/mhsa_wdog.sv
// Per-stage watchdog: counts enabled cycles since the last clear and flags the limit.
module mhsa_wdog #(
  parameter int LIMIT = 100000,
  parameter int W     = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [W-1:0] r_cnt;

  // Expiry fires on the cycle the count reaches LIMIT-1, i.e. the LIMIT-th enabled cycle.
  assign o_expire = i_enable && (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mhsa_scheduler.sv
// Sequences the enabled attention layers one at a time, with drain gaps and a per-stage watchdog.
// Handshake: layer_start[cur] is a level held for the whole stage; the stage ends on the first
// cycle layer_done[cur] is seen high while layer_start[cur] is high.
module mhsa_scheduler #(
  parameter int NUM_STAGES = 7,
  parameter int TIMEOUT    = 'd100000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] cfg_stage_en,
  input  logic [NUM_STAGES-1:0] layer_done,
  output logic [NUM_STAGES-1:0] layer_start,
  output logic [2:0]            bar_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_stage,
  output logic [2:0]            o_dbg_state
);

  import mhsa_pkg::*;

  mhsa_state_e           r_state, w_next;
  logic [NUM_STAGES-1:0] r_mask;
  logic                  r_go;
  logic [2:0]            r_cur;
  logic [2:0]            r_err_stage;
  logic [7:0]            r_gap;
  logic                  w_accept, w_load_cur, w_to_err, w_expire, w_found;
  logic [2:0]            w_idx;

  mhsa_wdog #(.LIMIT(TIMEOUT), .W(24)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != ST_RUN),
    .i_enable (r_state == ST_RUN),
    .o_expire (w_expire)
  );

  // Lowest enabled stage: from index 0 when launching, above the current stage when in GAP.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (r_mask[i] && (r_state != ST_GAP || i > int'(r_cur))) begin
        w_found = 1'b1;
        w_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load_cur = 1'b0;
    w_to_err   = 1'b0;
    w_accept   = (r_state == ST_IDLE) && start && !abort && !r_go;
    case (r_state)
      ST_IDLE: begin
        if (r_go) begin
          if (w_found) begin
            w_next     = ST_RUN;
            w_load_cur = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (layer_done[r_cur]) begin
          w_next = ST_GAP;
        end else if (w_expire) begin
          w_next   = ST_ERROR;
          w_to_err = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap == 8'(GAP_CYCLES - 1)) begin
          if (w_found) begin
            w_next     = ST_RUN;
            w_load_cur = 1'b1;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase
    if (abort) begin
      w_next     = ST_IDLE;
      w_load_cur = 1'b0;
      w_to_err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mask      <= '0;
      r_go        <= 1'b0;
      r_cur       <= '0;
      r_gap       <= '0;
      r_err_stage <= '0;
    end else begin
      r_state <= w_next;
      r_go    <= w_accept;
      if (w_accept) r_mask <= cfg_stage_en;
      if (w_load_cur) r_cur <= w_idx;
      if (r_state == ST_GAP) r_gap <= r_gap + 1'b1;
      else                   r_gap <= '0;
      if (w_to_err) r_err_stage <= r_cur;
    end
  end

  assign layer_start = (r_state == ST_RUN) ? (NUM_STAGES'(1) << r_cur) : '0;
  assign bar_sel     = r_cur;
  assign busy        = (r_state == ST_RUN) || (r_state == ST_GAP);
  assign done        = (r_state == ST_DONE);
  assign error       = (r_state == ST_ERROR);
  assign err_stage   = r_err_stage;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mhsa_scheduler.md
MHSA_SCHEDULER -- requirements
Module: mhsa_scheduler

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 7; number of sequenced layers (Q, K, V linear, QK matmul, softmax, SV matmul, out linear).
REQ-002 SHALL have parameter TIMEOUT, default 'd100000; watchdog limit in cycles per stage.
REQ-003 SHALL have parameter GAP_CYCLES, default 2; idle cycles between stages for bar write drain.
REQ-004 SHALL have port clk, input, 1; single clock, all logic on posedge.
REQ-005 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1; single-cycle request to run the enabled stage sequence.
REQ-007 SHALL have port abort, input, 1; terminate the current run and return to IDLE.
REQ-008 SHALL have port cfg_stage_en, input, NUM_STAGES; per-stage enable mask, sampled on accepted start.
REQ-009 SHALL have port layer_done, input, NUM_STAGES; level done from each layer.
REQ-010 SHALL have port layer_start, output, NUM_STAGES; level enable to each layer, at most one bit high.
REQ-011 SHALL have port bar_sel, output, 3; index of the stage owning memory bar0/bar1.
REQ-012 SHALL have ports busy, done, error, each output, 1: run in progress; one-cycle completion pulse; sticky timeout flag.
REQ-013 SHALL have port err_stage, output, 3; index of the stage that timed out.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP, DONE, ERROR.
REQ-015 IDLE: busy=0 and layer_start=0; start=1 latches cfg_stage_en into an internal mask.
REQ-016 From IDLE with a nonzero mask, the FSM SHALL enter RUN at the lowest enabled index; layer_start[idx] SHALL be high from the next cycle.
REQ-017 From IDLE with a zero mask, the FSM SHALL enter DONE on the next cycle.
REQ-018 RUN SHALL hold layer_start[cur]=1 and bar_sel=cur, and SHALL count cycles with a 24-bit watchdog that clears on RUN entry.
REQ-019 In RUN, layer_done[cur]=1 (including on the first RUN cycle) SHALL cause a move to GAP; layer_start SHALL go low in that same transition.
REQ-020 In RUN, when the watchdog reaches TIMEOUT-1 without done, the FSM SHALL move to ERROR with error=1 and err_stage=cur. If done and the timeout occur on the same cycle, done SHALL win.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with bar_sel held at cur, then enter RUN at the next higher enabled index, or DONE if none remains.
REQ-022 layer_done bits of non-current stages SHALL be ignored in every state.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-024 ERROR SHALL keep busy=0, layer_start=0, error=1 and err_stage held; start SHALL be ignored in ERROR; only abort or rst leaves ERROR.
REQ-025 busy SHALL be 1 in RUN and GAP and 0 in every other state.
REQ-026 start while busy=1 SHALL be ignored; the mask SHALL not change mid-run.
REQ-027 abort=1 in any state SHALL force IDLE on the next cycle with layer_start=0, error cleared, and no done pulse; abort SHALL take priority over start and layer_done in the same cycle.
REQ-028 bar_sel SHALL hold its last value in IDLE, DONE and ERROR.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, layer_start=0, bar_sel=0, busy=0, done=0, error=0, err_stage=0, mask=0, watchdog=0; rst SHALL override abort and start.

Structure
REQ-030 Package mhsa_pkg SHALL hold the state enum, NUM_STAGES, and the stage index constants STG_LIN_Q=0 .. STG_LIN_O=6.
REQ-031 The watchdog SHALL be a sub-module mhsa_wdog (clear, enable, expire at limit); the rest of the block is flat.

Verification
REQ-032 Full run: mask=7'h7F, each layer_done pulses 10 cycles after its start -> layer_start bits rise in order 0..6, bar_sel steps 0..6, 2-cycle gaps between stages, a single done pulse.
REQ-033 Skip: mask=7'b0010100 -> only stages 2 and 4 are started; bar_sel never takes any other value; done fires once.
REQ-034 Empty mask: mask=0, start -> done high for exactly 1 cycle, 2 cycles after start, with busy never high.
REQ-035 Timeout: TIMEOUT=50, stage 3 never completes -> error=1 and err_stage=3 at RUN cycle 50; start ignored in ERROR; abort clears error.
REQ-036 Stale done: layer_done[0] held high before start -> stage 0 ends after one RUN cycle; layer_done[5] toggling during stage 1 has no effect.
REQ-037 Abort in stage 4, plus rst mid-GAP -> IDLE next cycle, all layer_start=0, no done pulse; a fresh start runs the full sequence normally.
